ptt_ctrl: RTL and testbench

Transmit-request initiator that drives the PTT sequencer's `ptt_i` and consumes its PTT output as a grant. It converts the host transmit-enable and modulator data-valid into a clean PTT request, holds the DAC sample gate closed until the sequencer confirms the PA is keyed, and applies a hang time after data stops. It also releases the request and waits for the grant to fall before it will accept a new transmission. It sits between the host/modulator logic and the sequencer, in the 48 MHz clock domain.

---
 rtl/ptt_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ptt_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptt_ctrl.sv
// ptt_ctrl: transmit-request initiator for the PTT sequencer.
//   Turns host tx-enable + modulator data-valid into a PTT request, keeps the
//   DAC sample gate closed until the synchronised grant confirms the PA is
//   keyed, holds the request for a hang time after data stops, and waits for
//   the grant to fall before accepting a new transmission.
//
// Optional feature: define PTT_TOT_EN to build in the transmit time-out timer
//   (adds the TOT_TICKS parameter). Default build has no time-out timer.
//
// Parameters:
//   TICK_DIV     clk cycles per timer tick
//   GRANT_TICKS  ticks allowed in REQ waiting for the grant
//   HANG_TICKS   ticks the request is held after data_valid_i falls
//   TOT_TICKS    transmit time-out in ticks (PTT_TOT_EN only)
//
// Ports:
//   clk           system clock (48 MHz)
//   rst_n         asynchronous active-low reset
//   tx_en_i       host transmit enable (level)
//   data_valid_i  modulator has samples (level)
//   ptt_ack_i     grant from the sequencer, asynchronous
//   ptt_req_o     request to the sequencer
//   tx_gate_o     DAC sample output enable
//   fault_o       grant timeout, grant loss or time-out trip
//   state_o       current state encoding
module ptt_ctrl #(
  parameter int unsigned TICK_DIV    = 1024,
  parameter int unsigned GRANT_TICKS = 16384,
  parameter int unsigned HANG_TICKS  = 4688
`ifdef PTT_TOT_EN
  ,
  parameter int unsigned TOT_TICKS   = 14062500
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en_i,
  input  logic       data_valid_i,
  input  logic       ptt_ack_i,
  output logic       ptt_req_o,
  output logic       tx_gate_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam int unsigned TMR_W = 24;
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    TX    = 3'd2,
    HANG  = 3'd3,
    DRAIN = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [PRE_W-1:0]   pre_cnt;
  logic               tick;
  logic               ack_meta;
  logic               ack_s;
  logic [TMR_W-1:0]   timer;
  logic               timer_zero;
  logic               tot_expired;

  // Free-running prescaler; tick is high on the last count of each period.
  assign tick       = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign timer_zero = (timer == '0);

`ifdef PTT_TOT_EN
  logic [TMR_W-1:0] tot_cnt;

  // Time-out counter: armed once on REQ -> TX, keeps running through HANG
  // and back into TX so a hang re-key cannot extend the transmission.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tot_cnt <= '0;
    end else if ((state == REQ) && (state_n == TX)) begin
      tot_cnt <= TMR_W'(TOT_TICKS);
    end else if (((state == TX) || (state == HANG)) && tick && (tot_cnt != '0)) begin
      tot_cnt <= tot_cnt - TMR_W'(1);
    end
  end

  assign tot_expired = (tot_cnt == '0);
`else
  assign tot_expired = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (tx_en_i && data_valid_i) state_n = REQ;
      end
      REQ: begin
        // A grant arriving with the timeout still wins.
        if (ack_s)           state_n = TX;
        else if (!tx_en_i)   state_n = DRAIN;
        else if (timer_zero) state_n = FAULT;
      end
      TX, HANG: begin
        if (!ack_s)            state_n = FAULT;
        else if (tot_expired)  state_n = FAULT;
        else if (!tx_en_i)     state_n = DRAIN;
        else if (state == TX) begin
          if (!data_valid_i)   state_n = HANG;
        end else begin
          // Data returning on the expiry cycle keeps the PA keyed.
          if (data_valid_i)    state_n = TX;
          else if (timer_zero) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!ack_s) state_n = IDLE;
      end
      FAULT: begin
        if (!tx_en_i && !ack_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, prescaler, synchroniser, shared timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      ack_meta  <= 1'b0;
      ack_s     <= 1'b0;
      timer     <= '0;
      ptt_req_o <= 1'b0;
      tx_gate_o <= 1'b0;
      fault_o   <= 1'b0;
      state_o   <= 3'd0;
    end else begin
      pre_cnt  <= tick ? '0 : pre_cnt + PRE_W'(1);
      ack_meta <= ptt_ack_i;
      ack_s    <= ack_meta;
      state    <= state_n;

      // Reload on state entry; otherwise count ticks down to zero and hold.
      if (state_n != state) begin
        case (state_n)
          REQ:     timer <= TMR_W'(GRANT_TICKS);
          HANG:    timer <= TMR_W'(HANG_TICKS);
          default: timer <= '0;
        endcase
      end else if (tick && !timer_zero) begin
        timer <= timer - TMR_W'(1);
      end

      // Outputs decoded from the next state so they change with the state.
      ptt_req_o <= (state_n == REQ) || (state_n == TX) || (state_n == HANG);
      tx_gate_o <= (state_n == TX);
      fault_o   <= (state_n == FAULT);
      state_o   <= 3'(state_n);
    end
  end

endmodule

// File: tb/tb_ptt_ctrl.sv
`timescale 1ns/1ps
module tb_ptt_ctrl;

  localparam int TD = 4;
  localparam int GT = 8;
  localparam int HT = 5;
  localparam int TT = 50;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_TX    = 3'd2;
  localparam logic [2:0] S_HANG  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0;
  logic       dv = 1'b0;
  logic       ack = 1'b0;
  logic       req;
  logic       gate;
  logic       fault;
  logic [2:0] st;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ptt_ctrl #(
    .TICK_DIV(TD),
    .GRANT_TICKS(GT),
    .HANG_TICKS(HT)
`ifdef PTT_TOT_EN
    ,
    .TOT_TICKS(TT)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_en_i(tx_en),
    .data_valid_i(dv),
    .ptt_ack_i(ack),
    .ptt_req_o(req),
    .tx_gate_o(gate),
    .fault_o(fault),
    .state_o(st)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // {req, gate, fault, state}
  function automatic logic [5:0] outs();
    return {req, gate, fault, st};
  endfunction

  task automatic do_reset();
    tx_en = 1'b0;
    dv    = 1'b0;
    ack   = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns number of clocks until state_o == s, or -1 if the budget expires.
  task automatic wait_state(input logic [2:0] s, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (st == s) begin
        n = i;
        break;
      end
    end
  endtask

  // Gate must never be open without a request.
  always @(negedge clk) begin
    if (rst_n) begin
      n_chk++;
      if (gate && !req) begin
        n_fail++;
        $display("FAIL gate_without_req: gate=%0b req=%0b", gate, req);
      end
    end
  end

  // ---------------- reference model (event/tick-count based) ----------------
  int m_st, m_cyc, m_ticks, m_base, m_tot_base;
  logic m_a1, m_a2;

  function automatic logic [5:0] m_outs();
    logic r;
    r = (m_st == 1) || (m_st == 2) || (m_st == 3);
    return {r, logic'(m_st == 2), logic'(m_st == 5), 3'(m_st)};
  endfunction

  task automatic model_reset();
    m_st = 0; m_cyc = 0; m_ticks = 0; m_base = 0; m_tot_base = 0;
    m_a1 = 1'b0; m_a2 = 1'b0;
  endtask

  // Advances the model by one clock using the inputs held across that edge.
  task automatic model_step(input logic t, input logic d, input logic a);
    int  nst;
    int  tk;
    int  el;
    logic g;
    logic tot_exp;
    tk  = ((m_cyc % TD) == TD - 1) ? 1 : 0;
    g   = m_a2;
    el  = m_ticks - m_base;
    nst = m_st;
`ifdef PTT_TOT_EN
    tot_exp = (m_ticks - m_tot_base) >= TT;
`else
    tot_exp = 1'b0;
`endif
    case (m_st)
      0: if (t && d) nst = 1;
      1: if (g) nst = 2; else if (!t) nst = 4; else if (el >= GT) nst = 5;
      2: if (!g || tot_exp) nst = 5; else if (!t) nst = 4; else if (!d) nst = 3;
      3: if (!g || tot_exp) nst = 5; else if (!t) nst = 4; else if (d) nst = 2;
         else if (el >= HT) nst = 4;
      4: if (!g) nst = 0;
      5: if (!t && !g) nst = 0;
      default: nst = 0;
    endcase
    if (nst != m_st) m_base = m_ticks + tk;
    if (m_st == 1 && nst == 2) m_tot_base = m_ticks + tk;
    m_ticks += tk;
    m_cyc++;
    m_a2 = m_a1;
    m_a1 = a;
    m_st = nst;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       tx;
    logic       dv;
    logic       ack;
    int         cyc;
    logic       req;
    logic       gate;
    logic       fault;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int drops;
    int gate_seen;
    logic deaf;

    vecs[0]  = '{tx:0, dv:0, ack:0, cyc:3, req:0, gate:0, fault:0, st:S_IDLE};
    vecs[1]  = '{tx:1, dv:1, ack:0, cyc:1, req:1, gate:0, fault:0, st:S_REQ};
    vecs[2]  = '{tx:1, dv:1, ack:0, cyc:5, req:1, gate:0, fault:0, st:S_REQ};
    vecs[3]  = '{tx:1, dv:1, ack:1, cyc:2, req:1, gate:0, fault:0, st:S_REQ};
    vecs[4]  = '{tx:1, dv:1, ack:1, cyc:1, req:1, gate:1, fault:0, st:S_TX};
    vecs[5]  = '{tx:1, dv:0, ack:1, cyc:1, req:1, gate:0, fault:0, st:S_HANG};
    vecs[6]  = '{tx:1, dv:0, ack:1, cyc:4, req:1, gate:0, fault:0, st:S_HANG};
    vecs[7]  = '{tx:1, dv:1, ack:1, cyc:1, req:1, gate:1, fault:0, st:S_TX};
    vecs[8]  = '{tx:0, dv:1, ack:1, cyc:1, req:0, gate:0, fault:0, st:S_DRAIN};
    vecs[9]  = '{tx:0, dv:1, ack:0, cyc:2, req:0, gate:0, fault:0, st:S_DRAIN};
    vecs[10] = '{tx:0, dv:0, ack:0, cyc:1, req:0, gate:0, fault:0, st:S_IDLE};

    // Reset values
    do_reset();
    check("reset_outputs", 32'(outs()), 32'(6'b000000));

    for (int i = 0; i < 11; i++) begin
      tx_en = vecs[i].tx;
      dv    = vecs[i].dv;
      ack   = vecs[i].ack;
      repeat (vecs[i].cyc) @(negedge clk);
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].req, vecs[i].gate, vecs[i].fault, vecs[i].st}));
    end

    // Nominal key-up with ack 20 clks after the request
    do_reset();
    tx_en = 1'b1; dv = 1'b1;
    wait_state(S_REQ, 5, n);
    check("nom_req_1clk", 32'(n), 32'd1);
    repeat (20) @(negedge clk);
    ack = 1'b1;
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (gate) begin n = i; break; end
    end
    check("nom_gate_latency", 32'(n), 32'd3);
    dv = 1'b0;
    @(negedge clk);
    check("nom_gate_fall", 32'({gate, st}), 32'({1'b0, S_HANG}));
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!req) begin n = i; break; end
    end
    check_range("nom_hang_len", n, HT * TD - TD, HT * TD + TD);
    check("nom_drain", 32'(st), 32'(S_DRAIN));
    ack = 1'b0;
    wait_state(S_IDLE, 6, n);
    check("nom_idle_after_ack", 32'(n), 32'd3);

    // Hang re-key
    do_reset();
    ack = 1'b1; tx_en = 1'b1; dv = 1'b1;
    wait_state(S_TX, 10, n);
    check_range("rekey_to_tx", n, 1, 10);
    dv = 1'b0;
    drops = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      @(negedge clk);
      if (!req) drops++;
    end
    check("rekey_in_hang", 32'(st), 32'(S_HANG));
    dv = 1'b1;
    @(negedge clk);
    if (!req) drops++;
    check("rekey_back_tx", 32'({req, gate, st}), 32'({1'b1, 1'b1, S_TX}));
    check("rekey_req_drops", 32'(drops), 32'd0);

    // Grant timeout
    do_reset();
    tx_en = 1'b1; dv = 1'b1;
    wait_state(S_REQ, 5, n);
    wait_state(S_FAULT, 60, n);
    check_range("gto_len", n, GT * TD - TD, GT * TD + TD);
    check("gto_outputs", 32'({req, gate, fault}), 32'(3'b001));
    tx_en = 1'b0;
    @(negedge clk);
    check("gto_clear", 32'({fault, st}), 32'({1'b0, S_IDLE}));

    // Grant loss in TX
    do_reset();
    ack = 1'b1; tx_en = 1'b1; dv = 1'b1;
    wait_state(S_TX, 10, n);
    ack = 1'b0;
    repeat (2) @(negedge clk);
    check("loss_still_tx", 32'(st), 32'(S_TX));
    @(negedge clk);
    check("loss_fault", 32'({gate, fault, st}), 32'({1'b0, 1'b1, S_FAULT}));

    // Host abort in REQ
    do_reset();
    tx_en = 1'b1; dv = 1'b1;
    gate_seen = 0;
    repeat (3) begin @(negedge clk); if (gate) gate_seen++; end
    tx_en = 1'b0;
    @(negedge clk); if (gate) gate_seen++;
    check("abort_drain", 32'({req, st}), 32'({1'b0, S_DRAIN}));
    @(negedge clk); if (gate) gate_seen++;
    check("abort_idle", 32'(st), 32'(S_IDLE));
    check("abort_no_gate", 32'(gate_seen), 32'd0);

    // Time-out timer
    do_reset();
    ack = 1'b1; tx_en = 1'b1; dv = 1'b1;
    wait_state(S_TX, 10, n);
`ifdef PTT_TOT_EN
    wait_state(S_FAULT, TT * TD + 20, n);
    check_range("tot_trip", n, TT * TD - TD, TT * TD + TD);
    check("tot_fault", 32'(fault), 32'd1);
`else
    drops = 0;
    for (int i = 0; i < 110 * TD; i++) begin
      @(negedge clk);
      if (st != S_TX) drops++;
    end
    check("no_tot_persist", 32'(drops), 32'd0);
    check("no_tot_state", 32'({req, gate, st}), 32'({1'b1, 1'b1, S_TX}));
`endif

    // Asynchronous reset mid-TX
    do_reset();
    ack = 1'b1; tx_en = 1'b1; dv = 1'b1;
    wait_state(S_TX, 10, n);
    repeat (2) @(negedge clk);
    check("pre_rst_tx", 32'(st), 32'(S_TX));
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(outs()), 32'(6'b000000));
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised run against the reference model
    do_reset();
    model_reset();
    deaf = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      check($sformatf("rand_c%0d", c), 32'(outs()), 32'(m_outs()));
      if ($urandom_range(0, 299) == 0) deaf = ~deaf;
      if (!tx_en) begin if ($urandom_range(0, 9) == 0) tx_en = 1'b1; end
      else if ($urandom_range(0, 59) == 0) tx_en = 1'b0;
      if ($urandom_range(0, 11) == 0) dv = ~dv;
      if (deaf || !m_outs()[5]) begin
        if ($urandom_range(0, 3) == 0) ack = 1'b0;
      end else if (!ack) begin
        if ($urandom_range(0, 5) == 0) ack = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        ack = 1'b0;
      end
      model_step(tx_en, dv, ack);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
